// File: rtl/uart_pkg.sv
// Shared UART types and helpers: divisor struct, reset-default divisor
// calculation and the standard baud rates.
package uart_pkg;

    typedef struct packed {
        logic [31:0] div_int;
        logic [31:0] div_frac;
    } baud_div_t;

    localparam int unsigned BAUD_4800   = 4800;
    localparam int unsigned BAUD_9600   = 9600;
    localparam int unsigned BAUD_19200  = 19200;
    localparam int unsigned BAUD_38400  = 38400;
    localparam int unsigned BAUD_57600  = 57600;
    localparam int unsigned BAUD_115200 = 115200;
    localparam int unsigned BAUD_128000 = 128000;

    // clk_hz / (baud * oversample) in fixed point, rounded to the nearest
    // 1/2^frac_w, then split into integer and fractional parts.
    function automatic baud_div_t calc_div(input longint unsigned clk_hz,
                                           input longint unsigned baud,
                                           input longint unsigned oversample,
                                           input int unsigned     frac_w = 8);
        longint unsigned den;
        longint unsigned q;
        baud_div_t       r;
        den        = baud * oversample;
        q          = ((clk_hz << frac_w) + den / 2) / den;
        r.div_int  = 32'(q >> frac_w);
        r.div_frac = 32'(q & ((64'd1 << frac_w) - 1));
        return r;
    endfunction

endpackage

// File: rtl/uart_frac_div.sv
// Fractional divider: emits one rx_tick per div_int(+carry) clk cycles, with a
// shadow divisor that is only swapped in at a period boundary.
module uart_frac_div #(
    parameter int unsigned       DIV_W    = 16,
    parameter int unsigned       FRAC_W   = 8,
    parameter logic [DIV_W-1:0]  DEF_INT  = DIV_W'(2),
    parameter logic [FRAC_W-1:0] DEF_FRAC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [DIV_W-1:0]  load_int,
    input  logic [FRAC_W-1:0] load_frac,
    input  logic              restart,
    output logic              wrap,
    output logic              tick
);

    logic              run;
    logic              pend_vld;
    logic              start;
    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  act_int;
    logic [DIV_W-1:0]  pend_int;
    logic [DIV_W-1:0]  sel_int;
    logic [DIV_W-1:0]  reload;
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W-1:0] act_frac;
    logic [FRAC_W-1:0] pend_frac;
    logic [FRAC_W-1:0] sel_frac;
    logic [FRAC_W:0]   sum;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        sel_int  = act_int;
        sel_frac = act_frac;
        if (load) begin
            sel_int  = load_int;
            sel_frac = load_frac;
        end else if (pend_vld) begin
            sel_int  = pend_int;
            sel_frac = pend_frac;
        end
        sum    = {1'b0, acc} + {1'b0, sel_frac};
        // sel_int >= 2, so the reload value cannot wrap
        reload = sel_int - DIV_W'(1) + DIV_W'(sum[FRAC_W]);
        start  = en && (!run || restart);
        wrap   = en && run && !restart && (cnt == '0);
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run       <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            act_int   <= DEF_INT;
            act_frac  <= DEF_FRAC;
            pend_int  <= '0;
            pend_frac <= '0;
            pend_vld  <= 1'b0;
            tick      <= 1'b0;
        end else begin
            tick <= wrap;

            // Divisor swaps only when idle or at a boundary; otherwise park it.
            if (!en || start || wrap) begin
                act_int  <= sel_int;
                act_frac <= sel_frac;
                pend_vld <= 1'b0;
            end else if (load) begin
                pend_int  <= load_int;
                pend_frac <= load_frac;
                pend_vld  <= 1'b1;
            end

            if (!en) begin
                run <= 1'b0;
                cnt <= '0;
                acc <= '0;
            end else if (start) begin
                run <= 1'b1;
                cnt <= sel_int - DIV_W'(1);
                acc <= '0;
            end else if (wrap) begin
                cnt <= reload;
                acc <= sum[FRAC_W-1:0];
            end else begin
                cnt <= cnt - DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud generator: rx_tick at OVERSAMPLE x baud and tx_tick at baud, both
// single-cycle enables on clk, with a run-time programmable fractional divisor.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD_DEF   = BAUD_9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned FRAC_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              div_load,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              rx_restart,
    output logic              rx_tick,
    output logic              tx_tick,
    output logic              div_err
);

    localparam baud_div_t DIV_DEF = calc_div(64'(CLK_HZ), 64'(BAUD_DEF),
                                             64'(OVERSAMPLE), FRAC_W);
    localparam logic [DIV_W-1:0]  DIV_DEF_INT  = DIV_DEF.div_int[DIV_W-1:0];
    localparam logic [FRAC_W-1:0] DIV_DEF_FRAC = DIV_DEF.div_frac[FRAC_W-1:0];
    localparam int unsigned       OS_W         = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [OS_W-1:0]   OS_LAST      = OS_W'(OVERSAMPLE - 1);

    logic             bad_int;
    logic             wrap;
    logic [DIV_W-1:0] clamp_int;
    logic [OS_W-1:0]  os_cnt;

    // A divisor below 2 cannot produce distinct strobes; run at 2 and flag it.
    always_comb begin
        bad_int   = div_int < DIV_W'(2);
        clamp_int = bad_int ? DIV_W'(2) : div_int;
    end

    uart_frac_div #(
        .DIV_W    (DIV_W),
        .FRAC_W   (FRAC_W),
        .DEF_INT  (DIV_DEF_INT),
        .DEF_FRAC (DIV_DEF_FRAC)
    ) u_frac_div (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .load      (div_load),
        .load_int  (clamp_int),
        .load_frac (div_frac),
        .restart   (rx_restart),
        .wrap      (wrap),
        .tick      (rx_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            os_cnt  <= '0;
            tx_tick <= 1'b0;
            div_err <= 1'b0;
        end else begin
            tx_tick <= wrap && (os_cnt == OS_LAST);
            if (div_load) begin
                div_err <= bad_int;
            end
            if (!en || rx_restart) begin
                os_cnt <= '0;
            end else if (wrap) begin
                os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen: tick timestamps are collected from the
// outputs and compared against hand-computed cycle numbers.
module tb_uart_baud_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        div_load;
    logic        rx_restart;
    logic [15:0] div_int;
    logic [7:0]  div_frac;
    logic        rx_tick;
    logic        tx_tick;
    logic        div_err;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;
    int e;
    int t;
    int rx_q[$];
    int tx_q[$];

    uart_baud_gen dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .div_load   (div_load),
        .div_int    (div_int),
        .div_frac   (div_frac),
        .rx_restart (rx_restart),
        .rx_tick    (rx_tick),
        .tx_tick    (tx_tick),
        .div_err    (div_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stamp each strobe with the number of the edge that produced it.
    always @(negedge clk) begin
        if (rx_tick) rx_q.push_back(cyc);
        if (tx_tick) tx_q.push_back(cyc);
    end

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input int i, input int f);
        div_load = 1'b1;
        div_int  = 16'(i);
        div_frac = 8'(f);
        step();
        div_load = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget, input string tag);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            step();
            k++;
        end
        check(tag, longint'(rx_q.size() >= n), 1);
    endtask

    task automatic wait_tx(input int n, input int budget, input string tag);
        int k = 0;
        while (tx_q.size() < n && k < budget) begin
            step();
            k++;
        end
        check(tag, longint'(tx_q.size() >= n), 1);
    endtask

    // Disable, load a divisor while idle, clear the logs and enable again;
    // e is the edge that first samples en high.
    task automatic relaunch(input int i, input int f);
        en = 1'b0;
        load(i, f);
        rx_q.delete();
        tx_q.delete();
        en = 1'b1;
        e  = cyc + 1;
        step();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; en = 1'b0; div_load = 1'b0; rx_restart = 1'b0;
        div_int = '0; div_frac = '0;
        repeat (3) step();
        check("rst_rx_tick", rx_tick, 0);
        check("rst_tx_tick", tx_tick, 0);
        check("rst_div_err", div_err, 0);
        rst = 1'b1;
        step();

        // Integer divisor 4: rx every 4, tx every 64 on the 16th rx.
        relaunch(4, 0);
        wait_rx(1, 20, "t1_first_to");
        check("t1_latency", rx_q[0] - e, 4);
        wait_tx(2, 200, "t1_tx_to");
        check("t1_rx_period", rx_q[3] - rx_q[2], 4);
        check("t1_rx16", rx_q[15] - e, 64);
        check("t1_tx_first", tx_q[0] - e, 64);
        check("t1_tx_period", tx_q[1] - tx_q[0], 64);

        // Drop en mid-period: silence, then a full fresh first period.
        step();
        en = 1'b0;
        step();
        rx_q.delete();
        repeat (10) step();
        check("en0_quiet_rx", rx_q.size(), 0);
        check("en0_quiet_tx", tx_q.size(), 2);
        en = 1'b1;
        e  = cyc + 1;
        step();
        wait_rx(1, 20, "rearm_to");
        check("rearm_latency", rx_q[0] - e, 4);

        // 4 + 128/256: periods 4,5,4,5...; 16 periods take 72 cycles.
        relaunch(4, 128);
        wait_rx(19, 200, "t2_to");
        check("t2_latency", rx_q[0] - e, 4);
        check("t2_period_a", rx_q[1] - rx_q[0], 4);
        check("t2_period_b", rx_q[2] - rx_q[1], 5);
        check("t2_span16", rx_q[18] - rx_q[2], 72);

        // Reset defaults: 325 + 133/256; 128 periods = 41600 + 66 cycles.
        en = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        rx_q.delete();
        tx_q.delete();
        en = 1'b1;
        e  = cyc + 1;
        step();
        wait_rx(129, 45000, "def_to");
        check("def_latency", rx_q[0] - e, 325);
        check("def_span128", rx_q[128] - rx_q[0], 41666);
        check("def_tx_count", tx_q.size(), 8);
        check("def_div_err", div_err, 0);

        // Mid-period loads are deferred to the boundary; the last one wins.
        relaunch(4, 0);
        wait_rx(2, 20, "t4_to");
        step();
        load(6, 0);
        load(8, 0);
        wait_rx(4, 40, "t4_after_to");
        check("t4_cur_period", rx_q[2] - rx_q[1], 4);
        check("t4_next_period", rx_q[3] - rx_q[2], 8);

        // Restart on the cnt==0 cycle: no tick, fresh period, os_cnt cleared.
        relaunch(4, 0);
        wait_rx(2, 20, "t5_to");
        t = cyc;
        repeat (3) step();
        rx_restart = 1'b1;
        step();
        rx_restart = 1'b0;
        check("t5_no_tick", rx_q.size(), 2);
        wait_rx(3, 20, "t5_next_to");
        check("t5_next_tick", rx_q[2] - t, 8);
        wait_tx(1, 200, "t5_tx_to");
        check("t5_tx_after_restart", tx_q[0] - t, 68);

        // Divisor below 2: clamped to 2 and flagged; a legal load clears it.
        relaunch(4, 0);
        wait_rx(1, 20, "t6_to");
        step();
        load(1, 0);
        check("t6_err_set", div_err, 1);
        wait_rx(3, 40, "t6_a_to");
        check("t6_cur_period", rx_q[1] - rx_q[0], 4);
        check("t6_clamped_period", rx_q[2] - rx_q[1], 2);
        load(5, 0);
        check("t6_err_clear", div_err, 0);
        wait_rx(5, 40, "t6_b_to");
        check("t6_period_2", rx_q[3] - rx_q[2], 2);
        check("t6_period_5", rx_q[4] - rx_q[3], 5);
        load(0, 0);
        check("t6_err_set0", div_err, 1);
        wait_rx(6, 40, "t6_c_to");
        check("t6_tick_high", rx_tick, 1);
        load(1, 0);

        // Asynchronous reset with a divisor still pending.
        rst = 1'b0;
        #1;
        check("arst_rx_tick", rx_tick, 0);
        check("arst_tx_tick", tx_tick, 0);
        check("arst_div_err", div_err, 0);
        step();
        step();
        rx_q.delete();
        rst = 1'b1;
        e   = cyc + 1;
        step();
        wait_rx(1, 400, "arst_to");
        check("arst_default_div", rx_q[0] - e, 325);
        check("arst_err_after", div_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
